reg_wr_arbiter: RTL and testbench
=================================

Name: reg_wr_arbiter

Overview:
- Shares the single register-file write port, built from the synchronous-reset D flip-flop registers, between two requesters.
- Requester 0 is the ALU writeback path and requester 1 is the load-return path.
- Uses round-robin arbitration and a valid/grant handshake, with a registered write port to the register file.
- Sits between the execute/memory stages and the register file.

Parameters:
AW, 3, register address width (2^AW registers)
DW, 8, register data width
CW, 8, grant-counter width (ARB_STAT_EN only)

Ports:
CLK  input  1  clock; all state updates on the rising edge
R  input  1  reset, synchronous, active-high
HOLD  input  1  pipeline stall; suppresses all grants while high
REQ0  input  1  requester 0 write request
ADDR0  input  AW  requester 0 destination register
DATA0  input  DW  requester 0 write data
GNT0  output  1  requester 0 grant (combinational, same cycle)
REQ1  input  1  requester 1 write request
ADDR1  input  AW  requester 1 destination register
DATA1  input  DW  requester 1 write data
GNT1  output  1  requester 1 grant (combinational, same cycle)
WE  output  1  register-file write enable (registered)
WADDR  output  AW  register-file write address (registered)
WDATA  output  DW  register-file write data (registered)
LAST  output  1  index of the most recently granted requester (registered)
CONFLICT  output  1  registered flag: last cycle both requested the same ADDR
CNT0, CNT1  output  CW  saturating grant counters (ARB_STAT_EN only)

Behaviour:
- Reset:
  - One clock is used. R is synchronous and active-high.
  - On an edge with R=1: WE=0, WADDR=0, WDATA=0, LAST=0, CONFLICT=0, priority pointer PRI=0.
  - R has precedence over every other input. While R=1, GNT0 and GNT1 are forced to 0 combinationally.
- Handshake:
  - A requester holds REQx, ADDRx and DATAx stable until it sees GNTx=1 in the same cycle.
  - The transfer completes at that rising edge.
  - If REQx is still high in the next cycle, it is a new request.
- Grant logic (combinational; no grant when R=1 or HOLD=1):
  - Only REQ0: GNT0=1.
  - Only REQ1: GNT1=1.
  - Both requests: the requester indexed by PRI wins.
  - Never more than one grant in a cycle (GNT0 & GNT1 == 0).
- Priority pointer: on an edge where GNTx=1, PRI <= ~x. Otherwise PRI holds. This gives strict alternation under continuous contention.
- Write port (latency 1):
  - On an edge with GNTx=1: WE<=1, WADDR<=ADDRx, WDATA<=DATAx, LAST<=x.
  - With no grant: WE<=0, while WADDR, WDATA and LAST hold their values.
- CONFLICT: set on an edge where REQ0 & REQ1 & (ADDR0==ADDR1) and R=0 and HOLD=0. Otherwise cleared.
- HOLD=1: no grant, WE<=0, PRI unchanged. Pending requests stay pending.
- Reset mid-operation: any request pending on an R=1 edge is not written; the requester must re-present it after R falls. PRI restarts at 0.
- No write data is dropped: a losing requester keeps waiting and is guaranteed the grant in the next non-HOLD cycle.

Optional Feature:
- ARB_STAT_EN defined:
  - Ports CNT0 and CNT1 exist. Both clear to 0 on R.
  - CNTx increments by 1 on each edge with GNTx=1 and saturates at 2^CW-1 (no wrap).
- ARB_STAT_EN undefined: CNT0, CNT1 and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert R with REQ0=REQ1=1 -> GNT0=GNT1=0. After the next edge: WE=0, WADDR=0, WDATA=0, LAST=0, CONFLICT=0.
- Single request: REQ0=1, ADDR0=3, DATA0=8'hA5 -> GNT0=1 the same cycle. Next cycle: WE=1, WADDR=3, WDATA=8'hA5, LAST=0.
- Contention: REQ0=REQ1=1 held for 4 cycles after reset -> grants in order 0,1,0,1. WE=1 each following cycle, with WDATA alternating between DATA0 and DATA1.
- Conflict: REQ0=REQ1=1, ADDR0=ADDR1=5 -> one grant only, CONFLICT=1 next cycle. The loser is granted in the following cycle and writes to WADDR=5.
- HOLD: HOLD=1 for 3 cycles with REQ1=1 -> GNT1=0 and WE=0 throughout, PRI unchanged. On HOLD=0, GNT1=1 immediately.
- ARB_STAT_EN with CW=2: 5 consecutive grants to requester 0 -> CNT0 sequence 1,2,3,3,3 and CNT1=0. R=1 -> both counters clear to 0.

Source files
------------

// File: rtl/reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_wr_arbiter
// Purpose  : Round-robin arbiter sharing one registered register-file write
//            port between the ALU writeback (0) and load-return (1) paths.
//            Define ARB_STAT_EN to add saturating per-requester grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module reg_wr_arbiter #(
   parameter int AW = 3,
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic          CLK,
   input  logic          R,
   input  logic          HOLD,
   input  logic          REQ0,
   input  logic [AW-1:0] ADDR0,
   input  logic [DW-1:0] DATA0,
   output logic          GNT0,
   input  logic          REQ1,
   input  logic [AW-1:0] ADDR1,
   input  logic [DW-1:0] DATA1,
   output logic          GNT1,
   output logic          WE,
   output logic [AW-1:0] WADDR,
   output logic [DW-1:0] WDATA,
   output logic          LAST,
   output logic          CONFLICT
`ifdef ARB_STAT_EN
   ,
   output logic [CW-1:0] CNT0,
   output logic [CW-1:0] CNT1
`endif
);

   logic          r_pri;
   logic          r_we;
   logic [AW-1:0] r_waddr;
   logic [DW-1:0] r_wdata;
   logic          r_last;
   logic          r_conflict;
   logic          w_open;
   logic          w_gnt0;
   logic          w_gnt1;

   // Reset and stall both close the port; on contention the pointer picks the winner.
   assign w_open = ~R & ~HOLD;
   assign w_gnt0 = w_open & REQ0 & (~REQ1 | ~r_pri);
   assign w_gnt1 = w_open & REQ1 & (~REQ0 |  r_pri);

   assign GNT0     = w_gnt0;
   assign GNT1     = w_gnt1;
   assign WE       = r_we;
   assign WADDR    = r_waddr;
   assign WDATA    = r_wdata;
   assign LAST     = r_last;
   assign CONFLICT = r_conflict;

   always_ff @(posedge CLK) begin
      if (R) begin
         r_pri      <= 1'b0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_last     <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_conflict <= ~HOLD & REQ0 & REQ1 & (ADDR0 == ADDR1);
         if (w_gnt0 | w_gnt1) begin
            r_we    <= 1'b1;
            r_waddr <= w_gnt1 ? ADDR1 : ADDR0;
            r_wdata <= w_gnt1 ? DATA1 : DATA0;
            r_last  <= w_gnt1;
            // Hand priority to the requester that just lost (or did not ask).
            r_pri   <= w_gnt0;
         end else begin
            r_we    <= 1'b0;
         end
      end
   end

`ifdef ARB_STAT_EN
   logic [CW-1:0] r_cnt0;
   logic [CW-1:0] r_cnt1;

   always_ff @(posedge CLK) begin
      if (R) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_gnt0 && (r_cnt0 != {CW{1'b1}}))
            r_cnt0 <= r_cnt0 + 1'b1;
         if (w_gnt1 && (r_cnt1 != {CW{1'b1}}))
            r_cnt1 <= r_cnt1 + 1'b1;
      end
   end

   assign CNT0 = r_cnt0;
   assign CNT1 = r_cnt1;
`else
   localparam int c_unused_cw = CW;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_wr_arbiter
// Purpose  : Directed-vector bench for reg_wr_arbiter with a write-port
//            scoreboard fed by the stimulus and drained by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_wr_arbiter;

   localparam int AW = 3;
   localparam int DW = 8;
   localparam int CW = 2;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          l;
   } wr_t;

   logic          clk = 1'b0;
   logic          r = 1'b1, hold = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] data0 = '0, data1 = '0;
   logic          gnt0, gnt1, we, last, conflict;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
`ifdef ARB_STAT_EN
   logic [CW-1:0] cnt0, cnt1;
`endif

   int  n_cmp = 0;
   int  n_err = 0;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   reg_wr_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
      .CLK(clk), .R(r), .HOLD(hold),
      .REQ0(req0), .ADDR0(addr0), .DATA0(data0), .GNT0(gnt0),
      .REQ1(req1), .ADDR1(addr1), .DATA1(data1), .GNT1(gnt1),
      .WE(we), .WADDR(waddr), .WDATA(wdata), .LAST(last), .CONFLICT(conflict)
`ifdef ARB_STAT_EN
      , .CNT0(cnt0), .CNT1(cnt1)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; grants checked mid-cycle, conflict (econf >= 0)
   // is the registered result of the previous cycle.
   task automatic cyc(input logic rr, input logic hh,
                      input logic q0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic q1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic eg0, input logic eg1, input int econf);
      @(posedge clk);
      #1;
      r = rr; hold = hh;
      req0 = q0; addr0 = a0; data0 = d0;
      req1 = q1; addr1 = a1; data1 = d1;
      @(negedge clk);
      chk("gnt0", int'(gnt0), int'(eg0));
      chk("gnt1", int'(gnt1), int'(eg1));
      if (econf >= 0) chk("conflict", int'(conflict), econf);
      if (eg0) exp_q.push_back('{a: a0, d: d0, l: 1'b0});
      if (eg1) exp_q.push_back('{a: a1, d: d1, l: 1'b1});
   endtask

   task automatic idle(input int econf);
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, econf);
   endtask

   // Monitor: every grant must appear on the write port one edge later.
   always @(posedge clk) begin
      wr_t e;
      #3;
      if (we) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL spurious_write: got addr=%0d data=%0h last=%0d, required no write",
                     waddr, wdata, last);
         end else begin
            e = exp_q.pop_front();
            if ({waddr, wdata, last} !== e) begin
               n_err++;
               $display("FAIL write: got addr=%0d data=%0h last=%0d required addr=%0d data=%0h last=%0d",
                        waddr, wdata, last, e.a, e.d, e.l);
            end
         end
      end else if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         e = exp_q.pop_front();
         $display("FAIL missing_write: got WE=0 required addr=%0d data=%0h last=%0d",
                  e.a, e.d, e.l);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with both requests high: no grants, outputs cleared.
      cyc(1'b1, 1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 1'b0, -1);
      cyc(1'b1, 1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 1'b0, 0);
      chk("rst_we", int'(we), 0);
      chk("rst_waddr", int'(waddr), 0);
      chk("rst_wdata", int'(wdata), 0);
      chk("rst_last", int'(last), 0);

      // Single request from requester 0.
      cyc(1'b0, 1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, '0, '0, 1'b1, 1'b0, 0);
      idle(0);

      // Contention after reset: strict 0,1,0,1 alternation.
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 0);
      for (int k = 0; k < 4; k++)
         cyc(1'b0, 1'b0, 1'b1, 3'd1, 8'h10 + 8'(k), 1'b1, 3'd2, 8'h20 + 8'(k),
             (k % 2) == 0, (k % 2) == 1, 0);

      // Same address: one grant, CONFLICT next cycle, loser follows to addr 5.
      cyc(1'b0, 1'b0, 1'b1, 3'd5, 8'h55, 1'b1, 3'd5, 8'h66, 1'b1, 1'b0, 0);
      cyc(1'b0, 1'b0, 1'b0, 3'd5, 8'h55, 1'b1, 3'd5, 8'h66, 1'b0, 1'b1, 1);
      idle(0);

      // HOLD for three cycles with REQ1 pending, then released.
      for (int k = 0; k < 3; k++)
         cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 3'd7, 8'h77, 1'b0, 1'b0, 0);
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 3'd7, 8'h77, 1'b0, 1'b1, 0);

      // HOLD leaves the pointer alone: 0 wins, hold, then 1 wins.
      cyc(1'b0, 1'b0, 1'b1, 3'd4, 8'h44, 1'b1, 3'd6, 8'h88, 1'b1, 1'b0, 0);
      cyc(1'b0, 1'b1, 1'b1, 3'd4, 8'h45, 1'b1, 3'd6, 8'h88, 1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, 1'b1, 3'd4, 8'h45, 1'b1, 3'd6, 8'h88, 1'b0, 1'b0, 0);
      cyc(1'b0, 1'b0, 1'b1, 3'd4, 8'h45, 1'b1, 3'd6, 8'h88, 1'b0, 1'b1, 0);
      cyc(1'b0, 1'b0, 1'b1, 3'd4, 8'h45, 1'b0, '0, '0, 1'b1, 1'b0, 0);

      // Reset mid-operation drops pending requests and restarts the pointer.
      cyc(1'b1, 1'b0, 1'b1, 3'd2, 8'h99, 1'b1, 3'd3, 8'h9A, 1'b0, 1'b0, 0);
      cyc(1'b0, 1'b0, 1'b1, 3'd2, 8'h99, 1'b1, 3'd3, 8'h9A, 1'b1, 1'b0, 0);
      idle(0);

`ifdef ARB_STAT_EN
      begin
         int exp_cnt[5] = '{1, 2, 3, 3, 3};
         cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, -1);
         for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 3'(k), 8'hC0 + 8'(k), 1'b0, '0, '0, 1'b1, 1'b0, 0);
            if (k > 0) chk("cnt0", int'(cnt0), exp_cnt[k-1]);
         end
         idle(0);
         chk("cnt0_sat", int'(cnt0), exp_cnt[4]);
         chk("cnt1", int'(cnt1), 0);
         cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, -1);
         idle(0);
         chk("cnt0_rst", int'(cnt0), 0);
         chk("cnt1_rst", int'(cnt1), 0);
      end
`endif

      idle(-1);
      idle(-1);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
